// File: rtl/microwave_timer_core.sv
// Cook-time BCD countdown (m:ss), magnetron IDLE/COOK control and 7-segment decode.
// Optional build macro: MWC_BLANK_LEADING_ZERO_EN blanks the minutes display while m == 0.
module microwave_timer_core (
    input  logic       clock,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    output logic       mag_on,
    output logic       zero,
    output logic [6:0] sec_ones,
    output logic [6:0] sec_tens,
    output logic [6:0] mins
);

    typedef enum logic {
        IDLE = 1'b0,
        COOK = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] m;
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] m_next;
    logic [3:0] st_next;
    logic [3:0] so_next;

    logic       load_en;
    logic       tick_en;
    logic       start_ok;
    logic       stop_req;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Clamp a seconds-ones digit so it can move into the seconds-tens position.
    function automatic logic [3:0] clamp_tens(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    assign zero     = (m == 4'd0) && (st == 4'd0) && (so == 4'd0);
    assign mag_on   = (state == COOK);

    assign load_en  = !loadn && !mag_on && (data <= 4'd9);
    assign tick_en  = pgt_1Hz && mag_on && !zero;

    // Stop and door-open take priority over start; a start at 0:00 is refused.
    assign start_ok = !startn && stopn && door_closed && !zero;
    assign stop_req = !stopn || !door_closed || zero;

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COOK;
            COOK:    if (stop_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load and tick are exclusive through mag_on, so at most one branch fires.
    always_comb begin
        m_next  = m;
        st_next = st;
        so_next = so;
        if (load_en) begin
            m_next  = st;
            st_next = clamp_tens(so);
            so_next = data;
        end else if (tick_en) begin
            if (so != 4'd0) begin
                so_next = so - 4'd1;
            end else begin
                so_next = 4'd9;
                if (st != 4'd0) begin
                    st_next = st - 4'd1;
                end else begin
                    st_next = 4'd5;
                    m_next  = m - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            m  <= 4'd0;
            st <= 4'd0;
            so <= 4'd0;
        end else begin
            m  <= m_next;
            st <= st_next;
            so <= so_next;
        end
    end

    assign sec_ones = seg7(so);
    assign sec_tens = seg7(st);

`ifdef MWC_BLANK_LEADING_ZERO_EN
    assign mins = (m == 4'd0) ? 7'h00 : seg7(m);
`else
    assign mins = seg7(m);
`endif

endmodule

// File: tb/tb_microwave_timer_core.sv
// Directed and randomized bench for microwave_timer_core against a seconds-count reference model.
module tb_microwave_timer_core;

    logic       clock = 1'b0;
    logic       clearn = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic [3:0] data = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic       mag_on;
    logic       zero;
    logic [6:0] sec_ones;
    logic [6:0] sec_tens;
    logic [6:0] mins;

    int errors = 0;
    int checks = 0;

    // Reference state: whole cook time in seconds plus magnetron flag.
    int secs = 0;
    bit mon = 1'b0;

    always #5 clock = ~clock;

    microwave_timer_core dut (
        .clock      (clock),
        .clearn     (clearn),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .data       (data),
        .loadn      (loadn),
        .pgt_1Hz    (pgt_1Hz),
        .mag_on     (mag_on),
        .zero       (zero),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .mins       (mins)
    );

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [0:9];
        tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        if (d < 0 || d > 9) return 7'h00;
        return tab[d];
    endfunction

    function automatic logic [6:0] mins_exp(input int s);
`ifdef MWC_BLANK_LEADING_ZERO_EN
        if (s / 60 == 0) return 7'h00;
`endif
        return seg_of(s / 60);
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic verify();
        check("mag_on", {6'd0, mag_on}, {6'd0, mon});
        check("zero", {6'd0, zero}, {6'd0, (secs == 0)});
        check("sec_ones", sec_ones, seg_of(secs % 10));
        check("sec_tens", sec_tens, seg_of((secs % 60) / 10));
        check("mins", mins, mins_exp(secs));
    endtask

    // Advance one clock, updating the model from the inputs held during that cycle.
    task automatic cycle();
        int nsecs;
        bit nmon;
        bit z;
        int ones;
        z     = (secs == 0);
        nsecs = secs;
        nmon  = mon;
        if (!clearn) begin
            nsecs = 0;
            nmon  = 1'b0;
        end else begin
            if (!loadn && !mon && data <= 9) begin
                ones  = secs % 10;
                if (ones > 5) ones = 5;
                nsecs = ((secs % 60) / 10) * 60 + ones * 10 + int'(data);
            end
            if (pgt_1Hz && mon && !z) nsecs = secs - 1;
            if (!mon) nmon = !startn && stopn && door_closed && !z;
            else      nmon = stopn && door_closed && !z;
        end
        @(posedge clock);
        #1;
        secs = nsecs;
        mon  = nmon;
        verify();
    endtask

    task automatic load_digit(input int d);
        loadn = 1'b0;
        data  = 4'(d);
        cycle();
        loadn = 1'b1;
    endtask

    task automatic tick();
        pgt_1Hz = 1'b1;
        cycle();
        pgt_1Hz = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        cycle();
        startn = 1'b1;
    endtask

    task automatic do_reset();
        clearn = 1'b0;
        cycle();
        clearn = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_sec_ones", sec_ones, 7'h7E);
        check("rst_sec_tens", sec_tens, 7'h7E);
`ifdef MWC_BLANK_LEADING_ZERO_EN
        check("rst_mins", mins, 7'h00);
`else
        check("rst_mins", mins, 7'h7E);
`endif
        check("rst_zero", {6'd0, zero}, 7'd1);

        // Entry 1,3,0 -> 1:30
        load_digit(1);
        load_digit(3);
        load_digit(0);
        check("entry_mins", mins, 7'h30);
        check("entry_tens", sec_tens, 7'h79);
        check("entry_ones", sec_ones, 7'h7E);
        check("entry_zero", {6'd0, zero}, 7'd0);
        load_digit(12);
        check("entry_ignore_big", sec_tens, 7'h79);

        // Borrow 1:00 -> 0:59
        load_digit(1);
        load_digit(0);
        load_digit(0);
        press_start();
        check("borrow_mag", {6'd0, mag_on}, 7'd1);
        tick();
        check("borrow_tens", sec_tens, 7'h5B);
        check("borrow_ones", sec_ones, 7'h7B);
        stopn = 1'b0;
        cycle();
        stopn = 1'b1;

        // Run to end from 0:02
        do_reset();
        load_digit(2);
        press_start();
        tick();
        cycle();
        tick();
        check("end_zero", {6'd0, zero}, 7'd1);
        check("end_mag_still_on", {6'd0, mag_on}, 7'd1);
        cycle();
        check("end_mag_off", {6'd0, mag_on}, 7'd0);
        tick();
        tick();
        check("end_hold_ones", sec_ones, 7'h7E);

        // Pause on door open and resume at 0:45
        load_digit(4);
        load_digit(5);
        press_start();
        door_closed = 1'b0;
        cycle();
        check("door_mag_off", {6'd0, mag_on}, 7'd0);
        tick();
        tick();
        door_closed = 1'b1;
        check("pause_ones", sec_ones, 7'h5B);
        press_start();
        tick();
        check("resume_ones", sec_ones, 7'h33);
        loadn = 1'b0;
        data  = 4'd7;
        cycle();
        loadn = 1'b1;
        check("load_while_cook", sec_ones, 7'h33);
        pgt_1Hz = 1'b1;
        stopn   = 1'b0;
        cycle();
        pgt_1Hz = 1'b0;
        stopn   = 1'b1;
        check("tick_stop_ones", sec_ones, 7'h79);
        check("tick_stop_mag", {6'd0, mag_on}, 7'd0);

        // Stop beats start
        startn = 1'b0;
        stopn  = 1'b0;
        cycle();
        cycle();
        startn = 1'b1;
        stopn  = 1'b1;
        check("stop_wins", {6'd0, mag_on}, 7'd0);

        // Start at 0:00 refused
        do_reset();
        press_start();
        cycle();
        check("start_at_zero", {6'd0, mag_on}, 7'd0);

        // Clear mid-cook
        load_digit(9);
        press_start();
        tick();
        clearn = 1'b0;
        cycle();
        clearn = 1'b1;
        check("clear_mid_mag", {6'd0, mag_on}, 7'd0);
        check("clear_mid_zero", {6'd0, zero}, 7'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clearn      = ($urandom_range(0, 63) != 0);
            loadn       = ($urandom_range(0, 3) != 0);
            data        = 4'($urandom_range(0, 15));
            pgt_1Hz     = ($urandom_range(0, 2) == 0);
            startn      = ($urandom_range(0, 3) != 0);
            stopn       = ($urandom_range(0, 15) != 0);
            door_closed = ($urandom_range(0, 15) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
